// File: rtl/ro_cache_pkg.sv
// Shared types and helpers for the read-only block cache controller.
package ro_cache_pkg;

    // Controller states; FLUSH is the reset state so the sweep initialises storage.
    typedef enum logic [2:0] {
        ST_FLUSH     = 3'd0,
        ST_IDLE      = 3'd1,
        ST_MISS_REQ  = 3'd2,
        ST_MISS_WAIT = 3'd3,
        ST_RESPOND   = 3'd4
    } state_t;

    // Operation on the tag array's single write port (one per cycle at most).
    typedef enum logic [1:0] {
        WR_NONE  = 2'd0,
        WR_CLEAR = 2'd1,
        WR_FILL  = 2'd2,
        WR_TOUCH = 2'd3
    } wr_op_t;

    // Line layout for the default geometry (24-bit address, 8-bit index, 32-bit block).
    localparam int LINE_TAG_W  = 16;
    localparam int LINE_DATA_W = 32;

    typedef struct packed {
        logic [LINE_TAG_W-1:0]  tag;
        logic [LINE_DATA_W-1:0] data;
    } cache_line_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ro_cache_tagarray.sv
// Per-set tag/data/valid/MRU storage with one lookup port and one write port.
// Lookup is combinational: hit detection, hit data and the fill victim.
module ro_cache_tagarray
    import ro_cache_pkg::*;
#(
    parameter int SIZE_BLOCK = 32,
    parameter int BIT_TOTAL  = 24,
    parameter int BIT_INDEX  = 8,
    parameter int WAY        = 2,
    localparam int TAG_W     = BIT_TOTAL - BIT_INDEX,
    localparam int WAY_W     = (WAY > 1) ? clog2(WAY) : 1
)
(
    input  logic                  i_clk,
    input  logic [BIT_INDEX-1:0]  rd_set,
    input  logic [TAG_W-1:0]      rd_tag,
    output logic                  hit,
    output logic [WAY_W-1:0]      hit_way,
    output logic [SIZE_BLOCK-1:0] hit_data,
    output logic [WAY_W-1:0]      victim_way,
    input  wr_op_t                wr_op,
    input  logic [BIT_INDEX-1:0]  wr_set,
    input  logic [WAY_W-1:0]      wr_way,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [SIZE_BLOCK-1:0] wr_data
);

    localparam int LENGTH = 2 ** BIT_INDEX;

    // Storage is not reset: the controller's flush sweep clears valid/mru after reset.
    logic [TAG_W-1:0]      tag_r   [LENGTH][WAY];
    logic [SIZE_BLOCK-1:0] data_r  [LENGTH][WAY];
    logic [WAY-1:0]        valid_r [LENGTH];
    logic [WAY_W-1:0]      mru_r   [LENGTH];

    logic                  hit_s;
    logic [WAY_W-1:0]      hit_way_s;
    logic [SIZE_BLOCK-1:0] hit_data_s;
    logic                  match_s;
    logic                  inv_any_s;
    logic [WAY_W-1:0]      inv_way_s;
    logic [WAY_W-1:0]      rr_next_s;
    logic [WAY_W-1:0]      victim_s;

    // Apply the single write-port operation: clear a set, fill a way, or update MRU.
    always_ff @(posedge i_clk) begin
        case (wr_op)
            WR_CLEAR: begin
                valid_r[wr_set] <= '0;
                mru_r[wr_set]   <= '0;
            end
            WR_FILL: begin
                tag_r[wr_set][wr_way]   <= wr_tag;
                data_r[wr_set][wr_way]  <= wr_data;
                valid_r[wr_set][wr_way] <= 1'b1;
                mru_r[wr_set]           <= wr_way;
            end
            WR_TOUCH: begin
                mru_r[wr_set] <= wr_way;
            end
            default: begin
                mru_r[wr_set] <= mru_r[wr_set];
            end
        endcase
    end

    // Lookup: at most one way matches, so OR-merging the way data is safe.
    // Victim is the lowest invalid way, else the way after the MRU (round robin).
    always_comb begin
        hit_s      = 1'b0;
        hit_way_s  = '0;
        hit_data_s = '0;
        match_s    = 1'b0;
        inv_way_s  = '0;
        for (int w = 0; w < WAY; w++) begin
            match_s    = valid_r[rd_set][w] && (tag_r[rd_set][w] == rd_tag);
            hit_s      = hit_s | match_s;
            hit_way_s  = match_s ? WAY_W'(w) : hit_way_s;
            hit_data_s = hit_data_s | (match_s ? data_r[rd_set][w] : '0);
        end
        for (int w = WAY - 1; w >= 0; w--) begin
            inv_way_s = valid_r[rd_set][w] ? inv_way_s : WAY_W'(w);
        end
        inv_any_s = ~(&valid_r[rd_set]);
        rr_next_s = (mru_r[rd_set] == WAY_W'(WAY - 1)) ? '0 : (mru_r[rd_set] + WAY_W'(1));
        victim_s  = inv_any_s ? inv_way_s : rr_next_s;
    end

    assign hit        = hit_s;
    assign hit_way    = hit_way_s;
    assign hit_data   = hit_data_s;
    assign victim_way = victim_s;

endmodule

// File: rtl/ro_cache_ctrl.sv
// Blocking, set-associative, read-only block cache controller.
// Requester side and SDRAM side are Avalon-MM; one outstanding miss at a time.
module ro_cache_ctrl
    import ro_cache_pkg::*;
#(
    parameter int SIZE_BLOCK = 32,
    parameter int BIT_TOTAL  = 24,
    parameter int BIT_INDEX  = 8,
    parameter int WAY        = 2,
    parameter int BIT_CNT    = 32
)
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  s_read,
    input  logic [BIT_TOTAL-1:0]  s_address,
    output logic                  s_waitrequest,
    output logic [SIZE_BLOCK-1:0] s_readdata,
    output logic                  s_readdatavalid,
    output logic                  m_read,
    output logic [BIT_TOTAL-1:0]  m_address,
    input  logic                  m_waitrequest,
    input  logic [SIZE_BLOCK-1:0] m_readdata,
    input  logic                  m_readdatavalid,
    output logic [BIT_CNT-1:0]    o_hit_cnt,
    output logic [BIT_CNT-1:0]    o_miss_cnt,
    output logic                  o_busy
);

    localparam int TAG_W = BIT_TOTAL - BIT_INDEX;
    localparam int WAY_W = (WAY > 1) ? clog2(WAY) : 1;

    state_t                state_r;
    state_t                state_s;
    logic [BIT_INDEX-1:0]  sweep_r;
    logic [BIT_TOTAL-1:0]  addr_r;
    logic                  flush_pend_r;
    logic                  wait_r;
    logic                  busy_r;
    logic                  m_read_r;
    logic                  sdv_r;
    logic [SIZE_BLOCK-1:0] sdata_r;
    logic [BIT_CNT-1:0]    hit_cnt_r;
    logic [BIT_CNT-1:0]    miss_cnt_r;

    logic                  accept_s;
    logic                  is_hit_s;
    logic                  is_miss_s;
    logic                  fill_s;
    logic [BIT_INDEX-1:0]  rd_set_s;
    logic [TAG_W-1:0]      rd_tag_s;
    logic                  hit_s;
    logic [WAY_W-1:0]      hit_way_s;
    logic [SIZE_BLOCK-1:0] hit_data_s;
    logic [WAY_W-1:0]      victim_s;
    wr_op_t                wr_op_s;
    wr_op_t                wr_op_q_s;
    logic [BIT_INDEX-1:0]  wr_set_s;
    logic [WAY_W-1:0]      wr_way_s;

    // A flush pulse in IDLE wins over a simultaneous request.
    assign accept_s  = (state_r == ST_IDLE) && s_read && !i_flush;
    assign is_hit_s  = accept_s && hit_s;
    assign is_miss_s = accept_s && !hit_s;
    assign fill_s    = (state_r == ST_MISS_WAIT) && m_readdatavalid;

    // Lookup the live request in IDLE, otherwise the latched miss address.
    assign rd_set_s = (state_r == ST_IDLE) ? s_address[BIT_INDEX-1:0] : addr_r[BIT_INDEX-1:0];
    assign rd_tag_s = (state_r == ST_IDLE) ? s_address[BIT_TOTAL-1:BIT_INDEX] : addr_r[BIT_TOTAL-1:BIT_INDEX];

    // No storage writes while reset is held, so a late fill cannot land.
    assign wr_op_q_s = i_rst ? WR_NONE : wr_op_s;

    ro_cache_tagarray #(
        .SIZE_BLOCK (SIZE_BLOCK),
        .BIT_TOTAL  (BIT_TOTAL),
        .BIT_INDEX  (BIT_INDEX),
        .WAY        (WAY)
    ) u_tagarray (
        .i_clk      (i_clk),
        .rd_set     (rd_set_s),
        .rd_tag     (rd_tag_s),
        .hit        (hit_s),
        .hit_way    (hit_way_s),
        .hit_data   (hit_data_s),
        .victim_way (victim_s),
        .wr_op      (wr_op_q_s),
        .wr_set     (wr_set_s),
        .wr_way     (wr_way_s),
        .wr_tag     (addr_r[BIT_TOTAL-1:BIT_INDEX]),
        .wr_data    (m_readdata)
    );

    // Next-state and storage write selection.
    always_comb begin
        state_s  = state_r;
        wr_op_s  = WR_NONE;
        wr_set_s = rd_set_s;
        wr_way_s = victim_s;
        case (state_r)
            ST_FLUSH: begin
                wr_op_s  = WR_CLEAR;
                wr_set_s = sweep_r;
                if (&sweep_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_IDLE: begin
                if (i_flush) begin
                    state_s = ST_FLUSH;
                end else if (is_hit_s) begin
                    wr_op_s  = WR_TOUCH;
                    wr_way_s = hit_way_s;
                end else if (is_miss_s) begin
                    state_s = ST_MISS_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MISS_REQ: begin
                if (!m_waitrequest) begin
                    state_s = ST_MISS_WAIT;
                end else begin
                    state_s = ST_MISS_REQ;
                end
            end
            ST_MISS_WAIT: begin
                if (m_readdatavalid) begin
                    wr_op_s = WR_FILL;
                    state_s = ST_RESPOND;
                end else begin
                    state_s = ST_MISS_WAIT;
                end
            end
            ST_RESPOND: begin
                if (flush_pend_r || i_flush) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_FLUSH;
            end
        endcase
    end

    // State, sweep counter, miss address and pending-flush latch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_FLUSH;
            sweep_r      <= '0;
            addr_r       <= '0;
            flush_pend_r <= 1'b0;
        end else begin
            state_r <= state_s;
            sweep_r <= (state_r == ST_FLUSH) ? (sweep_r + BIT_INDEX'(1)) : '0;
            if (is_miss_s) begin
                addr_r <= s_address;
            end
            if (state_s == ST_FLUSH) begin
                flush_pend_r <= 1'b0;
            end else if (i_flush && (state_r != ST_IDLE) && (state_r != ST_FLUSH)) begin
                flush_pend_r <= 1'b1;
            end
        end
    end

    // Registered interface outputs derived from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_r   <= 1'b1;
            busy_r   <= 1'b1;
            m_read_r <= 1'b0;
            sdv_r    <= 1'b0;
            sdata_r  <= '0;
        end else begin
            wait_r   <= (state_s != ST_IDLE);
            busy_r   <= (state_s != ST_IDLE);
            m_read_r <= (state_s == ST_MISS_REQ);
            sdv_r    <= is_hit_s || fill_s;
            sdata_r  <= is_hit_s ? hit_data_s : (fill_s ? m_readdata : '0);
        end
    end

    // Saturating hit/miss statistics, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hit_cnt_r  <= '0;
            miss_cnt_r <= '0;
        end else begin
            if (is_hit_s && (hit_cnt_r != '1)) begin
                hit_cnt_r <= hit_cnt_r + BIT_CNT'(1);
            end
            if (is_miss_s && (miss_cnt_r != '1)) begin
                miss_cnt_r <= miss_cnt_r + BIT_CNT'(1);
            end
        end
    end

    assign s_waitrequest   = wait_r | i_flush;
    assign s_readdata      = sdata_r;
    assign s_readdatavalid = sdv_r;
    assign m_read          = m_read_r;
    assign m_address       = addr_r;
    assign o_hit_cnt       = hit_cnt_r;
    assign o_miss_cnt      = miss_cnt_r;
    assign o_busy          = busy_r;

endmodule

// File: tb/tb_ro_cache_ctrl.sv
// Directed bench for ro_cache_ctrl (default geometry: 256 sets, 2 ways).
module tb_ro_cache_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_flush = 1'b0;
    logic        s_read = 1'b0;
    logic [23:0] s_address = 24'h0;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic        m_read;
    logic [23:0] m_address;
    logic        m_waitrequest = 1'b0;
    logic [31:0] m_readdata = 32'h0;
    logic        m_readdatavalid = 1'b0;
    logic [31:0] o_hit_cnt;
    logic [31:0] o_miss_cnt;
    logic        o_busy;

    int tests = 0;
    int fails = 0;
    int exp_hit = 0;
    int exp_miss = 0;
    int exp_resp = 0;
    int xfer_cnt = 0;
    int mread_cyc = 0;
    int resp_cnt = 0;
    int idle_data_bad = 0;

    ro_cache_ctrl dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_flush         (i_flush),
        .s_read          (s_read),
        .s_address       (s_address),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_read          (m_read),
        .m_address       (m_address),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .o_hit_cnt       (o_hit_cnt),
        .o_miss_cnt      (o_miss_cnt),
        .o_busy          (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Count SDRAM handshakes and cycles with m_read high.
    always @(posedge i_clk) begin
        if (m_read && !m_waitrequest) xfer_cnt <= xfer_cnt + 1;
        if (m_read) mread_cyc <= mread_cyc + 1;
    end

    // Count responses and catch non-zero data outside a response.
    always @(negedge i_clk) begin
        if (s_readdatavalid) resp_cnt <= resp_cnt + 1;
        else if (s_readdata !== 32'h0) idle_data_bad <= idle_data_bad + 1;
    end

    // Count cycles with s_waitrequest high, starting at the current negedge.
    task automatic count_wait(output int n);
        n = 0;
        while (s_waitrequest === 1'b1 && n < 1000) begin
            n++;
            @(negedge i_clk);
        end
    endtask

    // Single-cycle read that must hit.
    task automatic read_hit(input logic [23:0] addr, input logic [31:0] data, input string name);
        int x0;
        x0 = xfer_cnt;
        s_read = 1'b1; s_address = addr;
        @(negedge i_clk);
        s_read = 1'b0; s_address = 24'h0;
        exp_hit++; exp_resp++;
        tests++;
        if (s_readdatavalid !== 1'b1 || s_readdata !== data)
            $display("FAIL %s_data: got valid=%b data=%h, expected valid=1 data=%h", name, s_readdatavalid, s_readdata, data);
        tests++;
        if (o_hit_cnt !== 32'(exp_hit))
            $display("FAIL %s_hitcnt: got %0d, expected %0d", name, o_hit_cnt, exp_hit);
        tests++;
        if (m_read !== 1'b0 || xfer_cnt !== x0)
            $display("FAIL %s_nomread: got m_read=%b xfers=%0d, expected 0 and %0d", name, m_read, xfer_cnt, x0);
        fails += (s_readdatavalid !== 1'b1 || s_readdata !== data) + (o_hit_cnt !== 32'(exp_hit)) + (m_read !== 1'b0 || xfer_cnt !== x0);
    endtask

    // Full miss: request, optional SDRAM stall, 2-cycle data return, response.
    task automatic do_miss(input logic [23:0] addr, input logic [31:0] data, input int stall,
                           input bit flush_mid, input string name);
        int x0, r0, bad, n;
        x0 = xfer_cnt; r0 = mread_cyc; bad = 0;
        s_read = 1'b1; s_address = addr; m_waitrequest = (stall > 0);
        @(negedge i_clk);
        s_read = 1'b0; s_address = 24'h0;
        exp_miss++; exp_resp++;
        tests++;
        if (s_readdatavalid !== 1'b0 || m_read !== 1'b1 || m_address !== addr) begin
            fails++;
            $display("FAIL %s_mreq: got dv=%b m_read=%b m_addr=%h, expected 0 1 %h", name, s_readdatavalid, m_read, m_address, addr);
        end
        tests++;
        if (o_miss_cnt !== 32'(exp_miss)) begin
            fails++;
            $display("FAIL %s_misscnt: got %0d, expected %0d", name, o_miss_cnt, exp_miss);
        end
        for (int k = 0; k < stall; k++) begin
            if (m_read !== 1'b1 || m_address !== addr) bad++;
            @(negedge i_clk);
        end
        m_waitrequest = 1'b0;
        @(negedge i_clk);
        tests++;
        if (bad != 0 || m_read !== 1'b0 || s_waitrequest !== 1'b1) begin
            fails++;
            $display("FAIL %s_hold: got bad=%0d m_read=%b wait=%b, expected 0 0 1", name, bad, m_read, s_waitrequest);
        end
        if (flush_mid) i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = data;
        @(negedge i_clk);
        m_readdatavalid = 1'b0; m_readdata = 32'h0;
        tests++;
        if (s_readdatavalid !== 1'b1 || s_readdata !== data) begin
            fails++;
            $display("FAIL %s_resp: got valid=%b data=%h, expected 1 %h", name, s_readdatavalid, s_readdata, data);
        end
        tests++;
        if (xfer_cnt - x0 != 1 || mread_cyc - r0 != stall + 1) begin
            fails++;
            $display("FAIL %s_xfer: got xfers=%0d mread_cycles=%0d, expected 1 %0d", name, xfer_cnt - x0, mread_cyc - r0, stall + 1);
        end
        @(negedge i_clk);
        if (flush_mid) begin
            count_wait(n);
            tests++;
            if (n != 256) begin
                fails++;
                $display("FAIL %s_flushlen: got %0d, expected 256", name, n);
            end
        end else begin
            tests++;
            if (s_waitrequest !== 1'b0 || s_readdatavalid !== 1'b0) begin
                fails++;
                $display("FAIL %s_idle: got wait=%b dv=%b, expected 0 0", name, s_waitrequest, s_readdatavalid);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        tests++;
        if (s_waitrequest !== 1'b1 || o_busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_wait: got wait=%b busy=%b, expected 1 1", s_waitrequest, o_busy);
        end
        tests++;
        if (m_read !== 1'b0 || s_readdatavalid !== 1'b0 || s_readdata !== 32'h0 || m_address !== 24'h0) begin
            fails++;
            $display("FAIL reset_outs: got m_read=%b dv=%b data=%h addr=%h, expected all 0", m_read, s_readdatavalid, s_readdata, m_address);
        end
        tests++;
        if (o_hit_cnt !== 32'h0 || o_miss_cnt !== 32'h0) begin
            fails++;
            $display("FAIL reset_cnt: got hit=%0d miss=%0d, expected 0 0", o_hit_cnt, o_miss_cnt);
        end
        i_rst = 1'b0;
        count_wait(n);
        tests++;
        if (n != 256) begin
            fails++;
            $display("FAIL sweep_len: got %0d, expected 256", n);
        end
        tests++;
        if (s_waitrequest !== 1'b0 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL sweep_done: got wait=%b busy=%b, expected 0 0", s_waitrequest, o_busy);
        end
    endtask

    task automatic test_miss_basic();
        do_miss(24'h000010, 32'hDEADBEEF, 0, 1'b0, "miss_basic");
    endtask

    task automatic test_back_to_back();
        int x0, bad;
        x0 = xfer_cnt; bad = 0;
        s_read = 1'b1; s_address = 24'h000010;
        for (int i = 0; i < 4; i++) begin
            if (s_waitrequest !== 1'b0) bad++;
            @(negedge i_clk);
            if (i == 3) begin s_read = 1'b0; s_address = 24'h0; end
            if (s_readdatavalid !== 1'b1 || s_readdata !== 32'hDEADBEEF) bad++;
        end
        exp_hit += 4; exp_resp += 4;
        @(negedge i_clk);
        tests++;
        if (bad != 0 || s_readdatavalid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_resp: got bad=%0d trailing_dv=%b, expected 0 0", bad, s_readdatavalid);
        end
        tests++;
        if (o_hit_cnt !== 32'd4 || xfer_cnt != x0) begin
            fails++;
            $display("FAIL b2b_cnt: got hits=%0d xfers=%0d, expected 4 %0d", o_hit_cnt, xfer_cnt, x0);
        end
    endtask

    task automatic test_victim();
        do_miss(24'h000110, 32'h11110110, 0, 1'b0, "fill_110");
        do_miss(24'h000210, 32'h22220210, 0, 1'b0, "fill_210");
        read_hit(24'h000110, 32'h11110110, "hit_110a");
        do_miss(24'h000310, 32'h33330310, 0, 1'b0, "fill_310");
        read_hit(24'h000110, 32'h11110110, "hit_110b");
        do_miss(24'h000210, 32'h22220211, 0, 1'b0, "refill_210");
    endtask

    task automatic test_stall();
        do_miss(24'h000055, 32'h5555AAAA, 5, 1'b0, "stall");
        read_hit(24'h000055, 32'h5555AAAA, "stall_hit");
    endtask

    task automatic test_flush_miss();
        do_miss(24'h000020, 32'h2020C0DE, 0, 1'b1, "flush_miss");
        do_miss(24'h000020, 32'h2020C0DF, 0, 1'b0, "post_flush_20");
        do_miss(24'h000110, 32'h11110112, 0, 1'b0, "post_flush_110");
    endtask

    task automatic test_flush_idle();
        int n, h0, m0;
        h0 = exp_hit; m0 = exp_miss;
        i_flush = 1'b1; s_read = 1'b1; s_address = 24'h000020;
        #1;
        tests++;
        if (s_waitrequest !== 1'b1) begin
            fails++;
            $display("FAIL flush_idle_wait: got %b, expected 1", s_waitrequest);
        end
        @(negedge i_clk);
        i_flush = 1'b0; s_read = 1'b0; s_address = 24'h0;
        count_wait(n);
        tests++;
        if (n != 256) begin
            fails++;
            $display("FAIL flush_idle_len: got %0d, expected 256", n);
        end
        tests++;
        if (o_hit_cnt !== 32'(h0) || o_miss_cnt !== 32'(m0)) begin
            fails++;
            $display("FAIL flush_idle_cnt: got hit=%0d miss=%0d, expected %0d %0d", o_hit_cnt, o_miss_cnt, h0, m0);
        end
        do_miss(24'h000020, 32'h2020BEEF, 0, 1'b0, "flush_idle_20");
    endtask

    task automatic test_reset_mid_miss();
        int n;
        m_waitrequest = 1'b1;
        s_read = 1'b1; s_address = 24'h000077;
        @(negedge i_clk);
        s_read = 1'b0; s_address = 24'h0;
        i_rst = 1'b1;
        @(negedge i_clk);
        tests++;
        if (m_read !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_mread: got %b, expected 0", m_read);
        end
        i_rst = 1'b0; m_waitrequest = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = 32'hBAD0BAD0;
        @(negedge i_clk);
        m_readdatavalid = 1'b0; m_readdata = 32'h0;
        count_wait(n);
        n = n + 1;
        tests++;
        if (n != 256 || o_hit_cnt !== 32'h0 || o_miss_cnt !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid_sweep: got len=%0d hit=%0d miss=%0d, expected 256 0 0", n, o_hit_cnt, o_miss_cnt);
        end
        exp_hit = 0; exp_miss = 0;
        do_miss(24'h000077, 32'h77777777, 0, 1'b0, "rst_mid_77");
    endtask

    initial begin
        @(negedge i_clk);
        test_reset();
        test_miss_basic();
        test_back_to_back();
        test_victim();
        test_stall();
        test_flush_miss();
        test_flush_idle();
        test_reset_mid_miss();
        repeat (2) @(negedge i_clk);
        tests++;
        if (resp_cnt != exp_resp) begin
            fails++;
            $display("FAIL resp_total: got %0d, expected %0d", resp_cnt, exp_resp);
        end
        tests++;
        if (idle_data_bad != 0) begin
            fails++;
            $display("FAIL idle_data: got %0d nonzero idle cycles, expected 0", idle_data_bad);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion, expected finish within budget");
        $fatal(1, "timeout");
    end

endmodule
